// File: rtl/t8x8_pkg.sv
// Shared parameters and types for the 8x8 transpose-array feeder.
// Tile geometry, emission length and the emitter state encoding.
package t8x8_pkg;

    localparam int unsigned N        = 8;
    localparam int unsigned DW       = 32;
    localparam int unsigned EMIT_LEN = 2 * N - 1;
    localparam int unsigned TW       = $clog2(EMIT_LEN);
    localparam int unsigned RW       = $clog2(N);

    typedef enum logic {
        IDLE,
        EMIT
    } fsm_e;

endpackage

// File: rtl/t8x8_feeder_if.sv
// Row-input handshake and wavefront-output bundle of the tile feeder.
// slave is the feeder's view, master is the producer/consumer view.
interface t8x8_feeder_if;
    import t8x8_pkg::*;

    logic            enable;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_row;
    logic [N*DW-1:0] x_out;
    logic [N-1:0]    v_out;
    logic [N-1:0]    clear_out;
    logic            start;
    logic            tile_done;
    logic            busy;

    modport master (
        output enable, in_valid, in_row,
        input  in_ready, x_out, v_out, clear_out, start, tile_done, busy
    );

    modport slave (
        input  enable, in_valid, in_row,
        output in_ready, x_out, v_out, clear_out, start, tile_done, busy
    );

endinterface

// File: rtl/pp_tile_buf.sv
// Two-bank ping-pong tile store with per-bank full flags and write/read bank pointers.
// One write port (whole row) and N read ports, one per lane, each reading its own column.
module pp_tile_buf
    import t8x8_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [N*DW-1:0] wr_row,
    input  logic            rd_release,
    output logic            rbank,
    output logic [1:0]      full,
    input  logic            rd_bank,
    input  logic [RW-1:0]   rd_row  [N],
    output logic [DW-1:0]   rd_word [N]
);

    logic [DW-1:0] mem [2][N][N];

    logic [1:0]    full_q, full_d;
    logic          wbank_q, wbank_d;
    logic          rbank_q, rbank_d;
    logic [RW-1:0] wrow_q, wrow_d;
    logic          wr_fire;

    // Ready comes from the registered flag only, so a bank freed this edge accepts next cycle.
    assign wr_ready = !full_q[wbank_q];
    assign wr_fire  = wr_valid && wr_ready;
    assign rbank    = rbank_q;
    assign full     = full_q;

    always_comb begin
        full_d  = full_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        wrow_d  = wrow_q;
        if (wr_fire) begin
            if (wrow_q == RW'(N - 1)) begin
                full_d[wbank_q] = 1'b1;
                wrow_d          = '0;
                wbank_d         = !wbank_q;
            end else begin
                wrow_d = wrow_q + RW'(1);
            end
        end
        if (rd_release) begin
            full_d[rbank_q] = 1'b0;
            rbank_d         = !rbank_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q  <= '0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            wrow_q  <= '0;
        end else begin
            full_q  <= full_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            wrow_q  <= wrow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int unsigned c = 0; c < N; c++) begin
                mem[wbank_q][wrow_q][c] <= wr_row[c*DW +: DW];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            rd_word[i] = mem[rd_bank][rd_row[i]][i];
        end
    end

endmodule

// File: rtl/t8x8_feeder.sv
// Tile feeder: buffers row-major tiles and emits them as a skewed diagonal wavefront.
// Lane i lags by i cycles; outputs are registered and advance only while enable is high.
module t8x8_feeder
    import t8x8_pkg::*;
(
    input logic          clk,
    input logic          reset,
    t8x8_feeder_if.slave fd
);

    fsm_e          state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic          load;
    logic          rd_release;
    logic          rd_bank;
    logic          rbank;
    logic [1:0]    full;
    logic          wr_ready;
    logic [RW-1:0] rd_row  [N];
    logic [DW-1:0] rd_word [N];

    logic [N*DW-1:0] x_d, x_q;
    logic [N-1:0]    v_d, v_q;
    logic [N-1:0]    clr_d, clr_q;
    logic            start_d, start_q;
    logic            done_d, done_q;

    pp_tile_buf u_buf (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (fd.in_valid),
        .wr_ready   (wr_ready),
        .wr_row     (fd.in_row),
        .rd_release (rd_release),
        .rbank      (rbank),
        .full       (full),
        .rd_bank    (rd_bank),
        .rd_row     (rd_row),
        .rd_word    (rd_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    // load marks an edge that registers beat t_d; rd_bank flips when chaining into the next tile.
    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        load       = 1'b0;
        rd_release = 1'b0;
        rd_bank    = rbank;
        unique case (state_q)
            IDLE: begin
                if (fd.enable && full[rbank]) begin
                    state_d = EMIT;
                    t_d     = '0;
                    load    = 1'b1;
                end
            end
            EMIT: begin
                if (fd.enable) begin
                    if (t_q == TW'(EMIT_LEN - 1)) begin
                        rd_release = 1'b1;
                        if (full[!rbank]) begin
                            t_d     = '0;
                            load    = 1'b1;
                            rd_bank = !rbank;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        t_d  = t_q + TW'(1);
                        load = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        int unsigned tn;
        logic        lane_v;
        tn      = 32'(t_d);
        x_d     = '0;
        v_d     = '0;
        clr_d   = '0;
        start_d = load;
        done_d  = load && (t_d == TW'(EMIT_LEN - 1));
        for (int unsigned i = 0; i < N; i++) begin
            lane_v    = load && (tn >= i) && (tn < i + N);
            rd_row[i] = RW'(tn - i);
            v_d[i]    = lane_v;
            clr_d[i]  = load && (tn == i);
            if (lane_v) begin
                x_d[i*DW +: DW] = rd_word[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q     <= '0;
            v_q     <= '0;
            clr_q   <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (fd.enable) begin
            x_q     <= x_d;
            v_q     <= v_d;
            clr_q   <= clr_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

    assign fd.in_ready  = wr_ready;
    assign fd.x_out     = x_q;
    assign fd.v_out     = v_q;
    assign fd.clear_out = clr_q;
    assign fd.start     = start_q;
    assign fd.tile_done = done_q;
    assign fd.busy      = (state_q == EMIT) || (|full);

endmodule

// File: tb/tb_t8x8_feeder.sv
// Directed bench for t8x8_feeder with a cycle-level reference model of the wavefront.
// Words are {tag, row, column} so every beat identifies its tile, row and lane.
module tb_t8x8_feeder;
    import t8x8_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    t8x8_feeder_if fd ();

    t8x8_feeder dut (
        .clk   (clk),
        .reset (reset),
        .fd    (fd)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [DW-1:0] word(input logic [7:0] tag, input int r, input int c);
        return {tag, 8'(r), 16'(c)};
    endfunction

    function automatic logic [N*DW-1:0] row_of(input logic [7:0] tag, input int r);
        logic [N*DW-1:0] v;
        for (int c = 0; c < N; c++) v[c*DW +: DW] = word(tag, r, c);
        return v;
    endfunction

    // Reference model state
    int           m_nfull, m_wrow, m_t;
    bit           m_emit;
    logic [7:0]   m_tags[$];
    logic [DW-1:0] e_x [N];
    logic [N-1:0] e_v, e_clr;
    logic         e_start, e_done;
    int           start_cnt, done_cnt, beats;

    task automatic model_reset();
        m_nfull = 0; m_wrow = 0; m_t = 0; m_emit = 0;
        m_tags.delete();
        for (int i = 0; i < N; i++) e_x[i] = '0;
        e_v = '0; e_clr = '0; e_start = 0; e_done = 0; beats = 0;
    endtask

    task automatic model_outputs();
        for (int i = 0; i < N; i++) begin
            e_v[i]   = m_emit && (m_t >= i) && (m_t < i + N);
            e_clr[i] = m_emit && (m_t == i);
            e_x[i]   = e_v[i] ? word(m_tags[0], m_t - i, i) : '0;
        end
        e_start = m_emit;
        e_done  = m_emit && (m_t == 2 * N - 2);
    endtask

    initial begin : monitor
        bit en_e, iv, rdy;
        logic [7:0] tag_in;
        model_reset();
        forever begin
            @(posedge clk);
            en_e = fd.enable; iv = fd.in_valid; tag_in = fd.in_row[DW-1 -: 8];
            if (reset) model_reset();
            else begin
                rdy = (m_nfull < 2);
                if (en_e) begin
                    if (m_emit) begin
                        if (m_t == 2 * N - 2) begin
                            void'(m_tags.pop_front());
                            m_nfull--;
                            if (m_nfull > 0) m_t = 0;
                            else m_emit = 0;
                        end else m_t++;
                    end else if (m_nfull > 0) begin
                        m_emit = 1; m_t = 0;
                    end
                    model_outputs();
                end
                if (iv && rdy) begin
                    if (m_wrow == N - 1) begin
                        m_wrow = 0; m_nfull++; m_tags.push_back(tag_in);
                    end else m_wrow++;
                end
            end
            #1;
            if (!reset) begin
                for (int i = 0; i < N; i++)
                    check($sformatf("x_lane%0d", i), fd.x_out[i*DW +: DW], e_x[i]);
                check("v_out", fd.v_out, e_v);
                check("clear_out", fd.clear_out, e_clr);
                check("start", fd.start, e_start);
                check("tile_done", fd.tile_done, e_done);
                check("in_ready", fd.in_ready, m_nfull < 2);
                check("busy", fd.busy, m_nfull > 0);
                if (en_e) begin
                    beats += $countones(fd.v_out);
                    if (fd.start) start_cnt++;
                    if (fd.tile_done) begin
                        done_cnt++;
                        check("tile_beats", beats, 64);
                        beats = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_tile(input logic [7:0] tag, input bit gap, input bit keep);
        bit acc;
        int n;
        for (int r = 0; r < N; r++) begin
            fd.in_valid = 1'b1;
            fd.in_row   = row_of(tag, r);
            acc = 0; n = 0;
            while (!acc && n < 300) begin
                @(posedge clk);
                acc = fd.in_ready;
                #1;
                n++;
            end
            if (!acc) check("send_timeout", 0, 1);
            if (gap) begin
                fd.in_valid = 1'b0;
                tick();
            end
        end
        if (!keep) fd.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((fd.busy || fd.start) && n < 400) begin
            tick();
            n++;
        end
        check("idle_timeout", fd.busy || fd.start, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_x"}, 64'(|fd.x_out), 0);
        check({tag, "_v"}, fd.v_out, 0);
        check({tag, "_clr"}, fd.clear_out, 0);
        check({tag, "_start"}, fd.start, 0);
        check({tag, "_done"}, fd.tile_done, 0);
        check({tag, "_busy"}, fd.busy, 0);
        check({tag, "_rdy"}, fd.in_ready, 1);
    endtask

    initial begin : main
        int n;
        fd.enable = 1'b1; fd.in_valid = 1'b0; fd.in_row = '0;
        tick(); tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Tile 0: contiguous, enable held high
        start_cnt = 0; done_cnt = 0;
        send_tile(8'h00, 0, 0);
        check("t0_no_beat_yet", fd.start, 0);
        tick();
        check("t0_start", fd.start, 1);
        check("t0_clr0", fd.clear_out, 8'h01);
        check("t0_v0", fd.v_out, 8'h01);
        check("t0_lane0_t0", fd.x_out[0 +: DW], 32'h0000_0000);
        tick();
        check("t0_clr1", fd.clear_out, 8'h02);
        check("t0_v1", fd.v_out, 8'h03);
        check("t0_lane0_t1", fd.x_out[0 +: DW], 32'h0001_0000);
        check("t0_lane1_t1", fd.x_out[DW +: DW], 32'h0000_0001);
        wait_idle();
        check("t0_start_cycles", start_cnt, 15);
        check("t0_done_pulses", done_cnt, 1);

        // Three tiles back-to-back with in_valid held high
        start_cnt = 0; done_cnt = 0;
        send_tile(8'h01, 0, 1);
        send_tile(8'h02, 0, 1);
        send_tile(8'h03, 0, 0);
        wait_idle();
        check("b2b_start_cycles", start_cnt, 45);
        check("b2b_done_pulses", done_cnt, 3);

        // enable low for 3 cycles at t = 5 while the next tile is written
        start_cnt = 0; done_cnt = 0;
        fork
            begin
                send_tile(8'h04, 0, 0);
                send_tile(8'h05, 0, 0);
            end
            begin
                n = 0;
                while (fd.clear_out != 8'h20 && n < 300) begin tick(); n++; end
                check("hold_found_t5", fd.clear_out, 8'h20);
                fd.enable = 1'b0;
                tick();
                check("hold_clr", fd.clear_out, 8'h20);
                check("hold_v", fd.v_out, 8'h3F);
                check("hold_lane5", fd.x_out[5*DW +: DW], 32'h0400_0005);
                tick(); tick();
                fd.enable = 1'b1;
            end
        join
        wait_idle();
        check("hold_start_cycles", start_cnt, 30);
        check("hold_done_pulses", done_cnt, 2);

        // Reset mid-emission at t = 9
        send_tile(8'h06, 0, 0);
        n = 0;
        while (fd.v_out != 8'hFC && n < 300) begin tick(); n++; end
        check("rst_found_t9", fd.v_out, 8'hFC);
        #2 reset = 1'b1;
        #1 check_all_zero("async_rst");
        @(posedge clk);
        #3 reset = 1'b0;
        check("rst_rdy_after", fd.in_ready, 1);
        tick();

        // Fresh tile with in_valid toggling
        start_cnt = 0; done_cnt = 0;
        send_tile(8'h07, 1, 0);
        wait_idle();
        check("gap_start_cycles", start_cnt, 15);
        check("gap_done_pulses", done_cnt, 1);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
